// File: rtl/axi_rr_arbiter4.sv
// Four-requester round-robin arbiter for a shared AXI channel.
// One manager is granted at a time and keeps the grant until its own finish pulse.
// A watchdog forcibly releases a grant held too long, and a sticky error flag
// records which requester timed out.
// Handshake: a grant is offered only from IDLE. It stays stable while in GRANT
// regardless of req, and is released only by the granted index's finish pulse
// or by the watchdog. Finish pulses from other indices are ignored.
// The FSM state is visible on busy, which is high exactly when the state is GRANT.
module axi_rr_arbiter4 #(
    parameter int                TMO_W      = 16,
    parameter logic [TMO_W-1:0]  TMO_CYCLES = 16'd1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
    input  logic       finish0,
    input  logic       finish1,
    input  logic       finish2,
    input  logic       finish3,
    input  logic       tmo_clr,
    output logic       gnt0,
    output logic       gnt1,
    output logic       gnt2,
    output logic       gnt3,
    output logic [3:0] sel,
    output logic       busy,
    output logic       tmo_err,
    output logic [1:0] tmo_id
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYCLES - {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       last_q, last_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tmo_err_q, tmo_err_d;
    logic [1:0]       tmo_id_q, tmo_id_d;

    logic [3:0] req_v;
    logic [3:0] fin_v;
    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       timeout;

    assign req_v = {req3, req2, req1, req0};
    assign fin_v = {finish3, finish2, finish1, finish0};

    // Round-robin pick: scan last+1, last+2, last+3, then last itself.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (req_v[idx] && !found) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Watchdog fires on the last allowed grant cycle unless the owner finishes then.
    assign timeout = (TMO_CYCLES != '0) && (cnt_q == TMO_LAST) && !fin_v[last_q];

    // Next-state and registered-output logic; last_q doubles as the owner index in GRANT.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tmo_err_d = tmo_err_q;
        tmo_id_d  = tmo_id_q;

        if (tmo_clr) begin
            tmo_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << winner;
                    last_d  = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
                if (fin_v[last_q]) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end else if (timeout) begin
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    tmo_err_d = 1'b1;
                    tmo_id_d  = last_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
            tmo_id_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
            tmo_id_q  <= tmo_id_d;
        end
    end

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign gnt2    = gnt_q[2];
    assign gnt3    = gnt_q[3];
    assign sel     = gnt_q;
    assign busy    = (state_q == GRANT);
    assign tmo_err = tmo_err_q;
    assign tmo_id  = tmo_id_q;

endmodule

// File: tb/tb_axi_rr_arbiter4.sv
// Bench for axi_rr_arbiter4: directed scenarios followed by random traffic,
// all compared each cycle against a behavioural owner/age model.
module tb_axi_rr_arbiter4;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] fin;
    logic       clr;
    logic       gnt0, gnt1, gnt2, gnt3;
    logic [3:0] sel;
    logic       busy;
    logic       tmo_err;
    logic [1:0] tmo_id;
    logic [3:0] gnt_vec;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, how many grant cycles have elapsed, fairness pointer.
    int         m_owner;
    int         m_age;
    int         m_last;
    logic       m_err;
    logic [1:0] m_id;

    assign gnt_vec = {gnt3, gnt2, gnt1, gnt0};

    // Clock generation.
    always #5 clk = ~clk;

    axi_rr_arbiter4 #(.TMO_W(16), .TMO_CYCLES(16'd8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
        .finish0(fin[0]), .finish1(fin[1]), .finish2(fin[2]), .finish3(fin[3]),
        .tmo_clr(clr),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3),
        .sel(sel), .busy(busy), .tmo_err(tmo_err), .tmo_id(tmo_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = 3;
        m_err   = 1'b0;
        m_id    = 2'd0;
    endtask

    // One clock edge of the arbitration rules, using the inputs present at the edge.
    task automatic model_step();
        bit set_now;
        set_now = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_age   = 0;
                    break;
                end
            end
        end else if (fin[m_owner]) begin
            m_owner = -1;
        end else if (m_age == TMO - 1) begin
            m_err   = 1'b1;
            m_id    = 2'(m_owner);
            m_owner = -1;
            set_now = 1'b1;
        end else begin
            m_age++;
        end
        if (clr && !set_now) m_err = 1'b0;
    endtask

    task automatic check_outputs();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk("gnt", {28'd0, gnt_vec}, {28'd0, eg});
        chk("sel", {28'd0, sel}, {28'd0, eg});
        chk("busy", {31'd0, busy}, {31'd0, (m_owner >= 0)});
        chk("tmo_err", {31'd0, tmo_err}, {31'd0, m_err});
        chk("tmo_id", {30'd0, tmo_id}, {30'd0, m_id});
        chk("sel_eq_gnt", {28'd0, sel}, {28'd0, gnt_vec});
        chk("sel_onehot0", {31'd0, $onehot0(sel)}, 32'd1);
    endtask

    // Advance one cycle: model follows the edge, outputs checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_outputs();
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (gnt_vec == 4'b0000 && n < 8) begin
            tick();
            n++;
        end
        chk("grant_wait", {31'd0, (gnt_vec != 4'b0000)}, 32'd1);
    endtask

    function automatic int gnt_index(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        int exp_order[6];
        int n;
        int idx;
        exp_order = '{0, 1, 2, 3, 0, 1};

        // Reset with every requester active.
        rst_n = 1'b0; req = 4'b1111; fin = 4'b0000; clr = 1'b0;
        model_reset();
        tick();
        tick();
        chk("reset_gnt", {28'd0, gnt_vec}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_tmo_err", {31'd0, tmo_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("first_grant_sel", {28'd0, sel}, 32'h1);

        // Fairness with all requests held: 0,1,2,3,0,1 with one dead cycle between.
        for (int i = 0; i < 6; i++) begin
            wait_grant(n);
            if (i > 0) chk("fair_latency", n, 1);
            idx = gnt_index(gnt_vec);
            chk("fair_order", idx, exp_order[i]);
            tick();
            tick();
            fin = 4'b0001 << exp_order[i];
            tick();
            fin = 4'b0000;
            chk("fair_gap", {28'd0, sel}, 32'd0);
        end
        req = 4'b0000;
        tick();

        // Single-cycle request on 1, finish after five grant cycles.
        req = 4'b0010;
        tick();
        req = 4'b0000;
        chk("single_gnt1", {28'd0, gnt_vec}, 32'h2);
        repeat (4) begin
            tick();
            chk("single_hold", {31'd0, gnt1}, 32'd1);
        end
        fin = 4'b0010;
        tick();
        fin = 4'b0000;
        chk("single_release", {31'd0, gnt1}, 32'd0);
        chk("single_busy", {31'd0, busy}, 32'd0);

        // Foreign finishes do not disturb the owner.
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("foreign_gnt2", {28'd0, gnt_vec}, 32'h4);
        fin = 4'b1001;
        tick();
        fin = 4'b0000;
        chk("foreign_hold", {28'd0, gnt_vec}, 32'h4);
        fin = 4'b0100;
        tick();
        fin = 4'b0000;
        chk("foreign_release", {28'd0, gnt_vec}, 32'd0);

        // Watchdog on a stalled requester 3.
        req = 4'b1000;
        tick();
        req = 4'b0000;
        repeat (7) tick();
        chk("tmo_still_held", {31'd0, gnt3}, 32'd1);
        tick();
        chk("tmo_dropped", {31'd0, gnt3}, 32'd0);
        chk("tmo_err_set", {31'd0, tmo_err}, 32'd1);
        chk("tmo_id_3", {30'd0, tmo_id}, 32'd3);
        req = 4'b1001;
        tick();
        chk("after_tmo_gnt0", {28'd0, gnt_vec}, 32'h1);
        req = 4'b0000;
        fin = 4'b0001;
        tick();
        fin = 4'b0000;

        // Clear and a new timeout in the same cycle: the set wins.
        req = 4'b0100;
        tick();
        req = 4'b0000;
        repeat (7) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_vs_set_err", {31'd0, tmo_err}, 32'd1);
        chk("clr_vs_set_id", {30'd0, tmo_id}, 32'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("tmo_clr", {31'd0, tmo_err}, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_when_clear", {31'd0, tmo_err}, 32'd0);

        // Finish on the last allowed cycle beats the watchdog.
        req = 4'b0010;
        tick();
        req = 4'b0000;
        repeat (7) tick();
        fin = 4'b0010;
        tick();
        fin = 4'b0000;
        chk("finish_at_limit_err", {31'd0, tmo_err}, 32'd0);
        chk("finish_at_limit_gnt", {28'd0, gnt_vec}, 32'd0);

        // Asynchronous reset mid-grant.
        req = 4'b1000;
        tick();
        chk("pre_reset_gnt3", {28'd0, gnt_vec}, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        req = 4'b0101;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_reset_gnt0", {28'd0, gnt_vec}, 32'h1);
        fin = 4'b0001;
        req = 4'b0000;
        tick();
        fin = 4'b0000;

        // Random traffic against the model.
        for (int t = 0; t < 400; t++) begin
            req = 4'($urandom_range(0, 15));
            fin = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        req = 4'b0000;
        fin = 4'b0000;
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_rr_arbiter4.md
Name: axi_rr_arbiter4

Overview:
Four-requester round-robin arbiter for the shared AXI write channel or the shared AXI read channel. It grants one bus manager at a time. The grant is held until that manager's finish pulse and drives the one-hot sel vector used by the top-level channel muxes. A per-grant watchdog forcibly releases a hung grant and records which requester timed out, so one stalled manager cannot lock the bus.

Parameters:
TMO_W, 16, width of the watchdog counter.
TMO_CYCLES, 16'd1024, cycles a grant may be held before forced release; 0 disables the watchdog.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req0..req3  input  1 each  request from manager 0..3
finish0..finish3  input  1 each  single-cycle transaction-complete pulse from manager 0..3
gnt0..gnt3  output  1 each  registered grant to manager 0..3
sel  output  4  one-hot mux select; sel[i] equals gnt_i
busy  output  1  high while in GRANT
tmo_err  output  1  sticky timeout flag
tmo_id  output  2  index of the requester that last timed out
tmo_clr  input  1  clears tmo_err

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; gnt0..3=0; sel=4'b0000; busy=0; tmo_err=0; tmo_id=0.
  - Watchdog counter=0; last-winner pointer=3, so requester 0 has top priority first.
- State machine has two states, IDLE and GRANT. All outputs are registered.
- IDLE:
  - If any req is high, choose the winner by scanning last+1, last+2, last+3, last (mod 4).
  - Assert gnt_winner and sel[winner] on the next edge. Set busy=1, last=winner, counter=0, and go to GRANT.
  - Latency from req rising (arbiter idle) to gnt is 1 cycle.
- GRANT:
  - gnt and sel hold constant and ignore req. A manager may drop req after gnt.
  - Only the finish of the granted index is honoured. finish from any other index is ignored and has no side effects.
  - On the granted finish: clear gnt/sel/busy on the next edge and return to IDLE.
  - New arbitration happens in IDLE, so the earliest next grant is 2 cycles after finish. This leaves one dead cycle with sel=0.
- Watchdog:
  - The counter increments every GRANT cycle, saturating at 2^TMO_W-1.
  - When TMO_CYCLES != 0 and counter == TMO_CYCLES-1 with no granted finish that cycle, perform a forced release. It behaves like a finish and, in addition, sets tmo_err=1 and tmo_id=granted index.
  - The last pointer stays at the timed-out index, so it gets lowest priority next round.
- Simultaneous events:
  - Granted finish and timeout in the same cycle: the finish wins and tmo_err is unchanged.
  - tmo_clr and a new timeout in the same cycle: the set wins, tmo_err stays 1 and tmo_id updates.
  - tmo_clr while tmo_err=0: no effect.
- Invariants (assert in bench):
  - At most one gnt is high.
  - sel is always 0 or one-hot and equals {gnt3,gnt2,gnt1,gnt0}.
- Reset mid-grant: all grants drop immediately (asynchronous) and priority returns to requester 0.

Test Plan:
- Reset state: hold rst_n=0 with req=4'b1111 → gnt=0, sel=0, busy=0, tmo_err=0. Release reset → gnt0 and sel=4'b0001 one cycle later.
- Single request: req1 pulsed for 1 cycle, finish1 issued 5 cycles after gnt1 → gnt1 held all 5 cycles; gnt1 low 1 cycle after finish1; busy tracks gnt1.
- Fairness: all four req held high, each manager finishing 3 cycles after its grant → grant order 0,1,2,3,0,1. Each grant is separated by exactly one sel=0 cycle.
- Foreign finish: gnt2 active, finish0 and finish3 pulsed → gnt2 unaffected. finish2 then releases it.
- Timeout: TMO_CYCLES=8, req3 only, no finish3 → gnt3 drops after 8 grant cycles, tmo_err=1, tmo_id=3. With req0 and req3 then both high → gnt0 first. tmo_clr pulse → tmo_err=0.
- Edge cases: finish at cycle 8 with TMO_CYCLES=8 → no error. rst_n asserted mid-grant → gnt/sel/busy cleared asynchronously; next grant goes to req0 when req0 and req2 are both high.
